wspr_sequencer: RTL and testbench
=================================

WSPR_SEQUENCER -- requirements
Module: wspr_sequencer

Interface
REQ-001 SHALL have parameter SYMBOL_CYCLES, default 52428800, giving clk cycles per WSPR symbol (8192/12000 s at 76.8 MHz).
REQ-002 SHALL have parameter NUM_SYMBOLS, default 162, giving symbols per transmission.
REQ-003 SHALL have parameter GUARD_CYCLES, default 76800, giving PTT lead and tail time in clk cycles (1 ms).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port base_freq, input, 32, phase increment of tone 0 (same format as the NCO frequency word).
REQ-007 SHALL have port tone_step, input, 32, phase increment between adjacent tones (about 1.4648 Hz).
REQ-008 SHALL have port sym_wr, input, 1, symbol-memory write strobe.
REQ-009 SHALL have port sym_addr, input, 8, symbol-memory write address.
REQ-010 SHALL have port sym_data, input, 2, symbol value 0..3.
REQ-011 SHALL have port start, input, 1, single-cycle trigger (even-minute sync).
REQ-012 SHALL have port abort, input, 1, level; terminates any transmission.
REQ-013 SHALL have port frequency, output, 32, registered phase increment to the transmitter NCO.
REQ-014 SHALL have port PTT, output, 1, registered transmit enable to the transmitter gate.
REQ-015 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle pulse on normal completion.
REQ-017 SHALL have port sym_index, output, 8, index of the current symbol.

Function
REQ-018 SHALL contain a NUM_SYMBOLS x 2-bit symbol memory with registered read.
REQ-019 SHALL accept sym_wr only in IDLE with sym_addr < NUM_SYMBOLS; all other writes are ignored without error.
REQ-020 SHALL implement states IDLE, LEAD, SEND and TAIL.
REQ-021 IDLE->LEAD on start; PTT goes high on the same edge; sym_index = 0.
REQ-022 LEAD->SEND after exactly GUARD_CYCLES cycles in LEAD.
REQ-023 SEND: symbol timer counts 0..SYMBOL_CYCLES-1; at terminal count, sym_index increments and the timer wraps to 0.
REQ-024 Each symbol is held for exactly SYMBOL_CYCLES cycles; SEND lasts NUM_SYMBOLS*SYMBOL_CYCLES cycles.
REQ-025 SEND->TAIL at terminal count of symbol NUM_SYMBOLS-1; sym_index holds NUM_SYMBOLS-1 and does not wrap.
REQ-026 TAIL->IDLE after GUARD_CYCLES cycles; PTT low, busy low and done high on that same edge.
REQ-027 frequency = base_freq + sym*tone_step, computed modulo 2^32 (wraps, no saturation).
REQ-028 frequency = base_freq in IDLE.
REQ-029 In LEAD, frequency shows the tone of symbol 0 from 2 cycles after entering LEAD.
REQ-030 In SEND, the tone for symbol k appears on frequency exactly 2 cycles after sym_index becomes k.
REQ-031 In TAIL, frequency holds the last symbol's tone.
REQ-032 A start pulse outside IDLE SHALL be ignored.
REQ-033 abort in any non-IDLE state forces IDLE on the next edge: PTT low, frequency = base_freq, no done pulse.
REQ-034 abort and start asserted in the same cycle: abort wins; state stays or goes IDLE.
REQ-035 base_freq and tone_step are sampled every cycle; a change mid-transmission takes effect within 2 cycles.
REQ-036 PTT SHALL be high only in LEAD, SEND and TAIL.

Reset
REQ-037 reset forces IDLE, PTT=0, busy=0, done=0, sym_index=0, frequency=0, and clears all counters, including mid-transmission.
REQ-038 Symbol memory contents are not cleared by reset.
REQ-039 reset has priority over abort, start and sym_wr.

Verification (SYMBOL_CYCLES=8, NUM_SYMBOLS=4, GUARD_CYCLES=3)
REQ-040 Write symbols 0,1,2,3; set base_freq=1000, tone_step=10; pulse start -> PTT high 3 cycles before SEND; frequency 1000,1010,1020,1030, each held 8 cycles; PTT drops 3 cycles after SEND; one done pulse; busy high for 3+32+3=38 cycles.
REQ-041 base_freq=0xFFFFFFF0, tone_step=0x10, symbol 3 -> frequency 0x00000020 (wrap).
REQ-042 abort asserted in SEND at symbol 2 -> next cycle PTT=0, busy=0, frequency=base_freq, no done pulse.
REQ-043 start pulsed during SEND, and sym_wr issued during SEND -> timing unchanged and memory unchanged after the run.
REQ-044 reset asserted mid-LEAD -> all outputs at reset values next cycle; a later start replays the previously loaded symbols.
REQ-045 start and abort in the same IDLE cycle -> remains IDLE with PTT low.

Source files
------------

// File: rtl/wspr_sequencer.sv
// WSPR transmit sequencer: steps through a stored 4-FSK symbol list at a fixed symbol rate,
// bracketing the transmission with PTT lead/tail guard time and driving the NCO frequency word.
module wspr_sequencer #(
  parameter int unsigned SYMBOL_CYCLES = 52428800,
  parameter int unsigned NUM_SYMBOLS   = 162,
  parameter int unsigned GUARD_CYCLES  = 76800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] base_freq,
  input  logic [31:0] tone_step,
  input  logic        sym_wr,
  input  logic [7:0]  sym_addr,
  input  logic [1:0]  sym_data,
  input  logic        start,
  input  logic        abort,
  output logic [31:0] frequency,
  output logic        PTT,
  output logic        busy,
  output logic        done,
  output logic [7:0]  sym_index
);

  localparam int unsigned CNT_MAX = (SYMBOL_CYCLES > GUARD_CYCLES) ? SYMBOL_CYCLES : GUARD_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned ADDR_W  = (NUM_SYMBOLS > 2) ? $clog2(NUM_SYMBOLS) : 1;

  localparam logic [CNT_W-1:0] SYM_LAST   = CNT_W'(SYMBOL_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [7:0]       IDX_LAST   = 8'(NUM_SYMBOLS - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SEND, TAIL} state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] timer_q, timer_n;
  logic [7:0]       idx_n;
  logic             done_n;
  logic [31:0]      freq_n;
  logic [31:0]      tone_off;
  logic [1:0]       rd_sym;
  logic [1:0]       mem [NUM_SYMBOLS];

  // Symbol memory: writable only while idle, never cleared by reset
  always_ff @(posedge clk) begin
    if (!reset && sym_wr && (state_q == IDLE) && (32'(sym_addr) < NUM_SYMBOLS))
      mem[ADDR_W'(sym_addr)] <= sym_data;
    rd_sym <= mem[ADDR_W'(sym_index)];
  end

  // Tone offset = rd_sym * tone_step, modulo 2^32
  always_comb begin
    tone_off = 32'd0;
    case (rd_sym)
      2'd1:    tone_off = tone_step;
      2'd2:    tone_off = 32'(tone_step << 1);
      2'd3:    tone_off = 32'(tone_step + 32'(tone_step << 1));
      default: tone_off = 32'd0;
    endcase
  end

  // Next-state and next-output logic; abort overrides every non-idle transition
  always_comb begin
    state_n = state_q;
    timer_n = timer_q;
    idx_n   = sym_index;
    done_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_n = LEAD;
          timer_n = '0;
          idx_n   = 8'd0;
        end
      end
      LEAD: begin
        if (timer_q == GUARD_LAST) begin
          state_n = SEND;
          timer_n = '0;
        end else begin
          timer_n = CNT_W'(timer_q + 1'b1);
        end
      end
      SEND: begin
        if (timer_q == SYM_LAST) begin
          timer_n = '0;
          if (sym_index == IDX_LAST) state_n = TAIL;
          else                       idx_n   = 8'(sym_index + 8'd1);
        end else begin
          timer_n = CNT_W'(timer_q + 1'b1);
        end
      end
      TAIL: begin
        if (timer_q == GUARD_LAST) begin
          state_n = IDLE;
          timer_n = '0;
          idx_n   = 8'd0;
          done_n  = 1'b1;
        end else begin
          timer_n = CNT_W'(timer_q + 1'b1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_n = IDLE;
      timer_n = '0;
      idx_n   = 8'd0;
      done_n  = 1'b0;
    end
    freq_n = (state_n == IDLE) ? base_freq : 32'(base_freq + tone_off);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      sym_index <= 8'd0;
      PTT       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frequency <= 32'd0;
    end else begin
      state_q   <= state_n;
      timer_q   <= timer_n;
      sym_index <= idx_n;
      PTT       <= (state_n != IDLE);
      busy      <= (state_n != IDLE);
      done      <= done_n;
      frequency <= freq_n;
    end
  end

endmodule

// File: tb/tb_wspr_sequencer.sv
// Directed bench for wspr_sequencer with 8-cycle symbols, 4 symbols and 3-cycle guard time.
module tb_wspr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] base_freq;
  logic [31:0] tone_step;
  logic        sym_wr;
  logic [7:0]  sym_addr;
  logic [1:0]  sym_data;
  logic        start;
  logic        abort;
  logic [31:0] frequency;
  logic        PTT;
  logic        busy;
  logic        done;
  logic [7:0]  sym_index;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_sym [4];

  wspr_sequencer #(.SYMBOL_CYCLES(8), .NUM_SYMBOLS(4), .GUARD_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .base_freq(base_freq), .tone_step(tone_step),
    .sym_wr(sym_wr), .sym_addr(sym_addr), .sym_data(sym_data),
    .start(start), .abort(abort), .frequency(frequency), .PTT(PTT),
    .busy(busy), .done(done), .sym_index(sym_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic write_sym(input logic [7:0] addr, input logic [1:0] data);
    sym_wr = 1'b1; sym_addr = addr; sym_data = data;
    @(negedge clk);
    sym_wr = 1'b0;
  endtask

  // Expected tone for sample c after the start edge (hand-derived timeline)
  function automatic logic [31:0] exp_freq(input int c);
    int k;
    if (c >= 38) return base_freq;
    k = (c < 13) ? 0 : (c < 21) ? 1 : (c < 29) ? 2 : 3;
    return 32'(base_freq + 32'(exp_sym[k]) * tone_step);
  endfunction

  // Full transmission: LEAD c=0..2, SEND c=3..34, TAIL c=35..37, idle with done at c=38
  task automatic run_full(input string tag, input bit inject);
    int done_count;
    done_count = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      int ks;
      ks = (c < 3) ? 0 : ((c - 3) / 8 > 3 ? 3 : (c - 3) / 8);
      if (done) done_count++;
      check($sformatf("%s ptt c=%0d", tag, c), 32'(PTT), 32'(c <= 37));
      check($sformatf("%s busy c=%0d", tag, c), 32'(busy), 32'(c <= 37));
      check($sformatf("%s done c=%0d", tag, c), 32'(done), 32'(c == 38));
      if (c <= 37)
        check($sformatf("%s idx c=%0d", tag, c), 32'(sym_index), 32'(ks));
      if (c >= 2)
        check($sformatf("%s freq c=%0d", tag, c), frequency, exp_freq(c));
      if (inject && c == 10) begin
        start = 1'b1; sym_wr = 1'b1; sym_addr = 8'd1; sym_data = 2'd3;
      end else begin
        start = 1'b0; sym_wr = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, " done pulses"}, 32'(done_count), 32'd1);
  endtask

  initial begin
    reset = 1'b1; base_freq = 32'd1000; tone_step = 32'd10;
    sym_wr = 1'b0; sym_addr = 8'd0; sym_data = 2'd0; start = 1'b0; abort = 1'b0;
    exp_sym[0] = 2'd0; exp_sym[1] = 2'd1; exp_sym[2] = 2'd2; exp_sym[3] = 2'd3;
    @(negedge clk);
    @(negedge clk);
    check("rst ptt", 32'(PTT), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst idx", 32'(sym_index), 32'd0);
    check("rst freq", frequency, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle freq", frequency, 32'd1000);

    for (int i = 0; i < 4; i++) write_sym(8'(i), 2'(i));
    run_full("basic", 1'b0);

    // Wrapping tone arithmetic, then abort from LEAD
    write_sym(8'd0, 2'd3);
    base_freq = 32'hFFFF_FFF0; tone_step = 32'h10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("wrap freq", frequency, 32'h0000_0020);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("lead abort ptt", 32'(PTT), 32'd0);
    check("lead abort freq", frequency, 32'hFFFF_FFF0);
    check("lead abort done", 32'(done), 32'd0);
    write_sym(8'd0, 2'd0);
    base_freq = 32'd1000; tone_step = 32'd10;
    @(negedge clk);

    // Abort during symbol 2
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20; c++) @(negedge clk);
    check("pre abort idx", 32'(sym_index), 32'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort ptt", 32'(PTT), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort freq", frequency, 32'd1000);
    check("abort done", 32'(done), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("post abort done %0d", c), 32'(done), 32'd0);
    end

    // start and sym_wr issued mid-SEND are ignored; memory verified by a second run
    run_full("inject", 1'b1);
    run_full("replay", 1'b0);

    // Reset mid-LEAD, then replay stored symbols
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid rst ptt", 32'(PTT), 32'd0);
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst done", 32'(done), 32'd0);
    check("mid rst idx", 32'(sym_index), 32'd0);
    check("mid rst freq", frequency, 32'd0);
    @(negedge clk);
    run_full("after rst", 1'b0);

    // start with abort in IDLE, and an out-of-range write
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start+abort ptt", 32'(PTT), 32'd0);
    check("start+abort busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("start+abort busy2", 32'(busy), 32'd0);
    write_sym(8'd4, 2'd3);
    write_sym(8'd200, 2'd2);
    run_full("oob wr", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
